// File: rtl/mode7_pkg.sv
// Shared Mode7 affine-datapath definitions: default operand format, sign-magnitude
// saturation constants (also used by the downstream adder) and multiplier FSM states.
package mode7_pkg;

    localparam int DEF_SIZE = 16;
    localparam int DEF_FRAC = 8;

    localparam logic [DEF_SIZE-1:0] UPPER_BOUND = 16'h7FFF;
    localparam logic [DEF_SIZE-1:0] SATURATED   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/smag_fx_mult_if.sv
// Operand/product handshake bundle for the sign-magnitude fixed-point multiplier.
interface smag_fx_mult_if
    import mode7_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/smag_fx_mult.sv
// Iterative shift-add sign-magnitude fixed-point multiplier: one multiplier bit per
// cycle, then a truncating/saturating normalize step into the adder's format.
module smag_fx_mult
    import mode7_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int FRAC = DEF_FRAC
) (
    input  logic            clk,
    input  logic            rst,
    smag_fx_mult_if.slave   bus
);
    localparam int MW = SIZE - 1;
    localparam int AW = 2 * MW;
    localparam int CW = $clog2(SIZE - 1);
    localparam logic [AW-1:0] MAG_MAX = {{MW{1'b0}}, {MW{1'b1}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 2);

    mult_state_t     state_q, state_d;
    logic [MW-1:0]   mag_a_q, mag_b_q;
    logic            sign_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] out_q;

    logic            accept;
    logic [AW-1:0]   p;
    logic [MW-1:0]   mag;

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;

    // Truncate toward zero, then clamp to the largest representable magnitude.
    assign p   = acc_q >> FRAC;
    assign mag = (p > MAG_MAX) ? {MW{1'b1}} : p[MW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)          state_d = MUL;
            MUL:  if (cnt_q == CNT_LAST)     state_d = NORM;
            NORM:                            state_d = DONE;
            DONE: if (bus.out_ready)         state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            if (accept) begin
                mag_a_q <= bus.in_a[MW-1:0];
                mag_b_q <= bus.in_b[MW-1:0];
                sign_q  <= bus.in_a[SIZE-1] ^ bus.in_b[SIZE-1];
                acc_q   <= '0;
                cnt_q   <= '0;
            end
            if (state_q == MUL) begin
                if (mag_b_q[cnt_q]) acc_q <= acc_q + ({{MW{1'b0}}, mag_a_q} << cnt_q);
                cnt_q <= cnt_q + 1'b1;
            end
            // A zero magnitude drops the sign so -0 never reaches the adder.
            if (state_q == NORM) out_q <= {sign_q & (|mag), mag};
        end
    end

endmodule
